// File: rtl/serializer_pkg.sv
// Shared types for the parallel-to-serial transmit stage.
package serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_e;

endpackage

// File: rtl/serializer_if.sv
// Word-in / slice-out bundle: valid/ready word input plus the registered serial lane.
interface serializer_if #(
  parameter int D = 8,
  parameter int S = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [D*S-1:0]   in_data;
  logic [D-1:0]     out_data;
  logic             out_frame_start;
  logic             out_active;

  modport master (
    output in_valid, in_data,
    input  in_ready, out_data, out_frame_start, out_active
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, out_data, out_frame_start, out_active
  );
endinterface

// File: rtl/serializer_holding_reg.sv
// One-entry pending register; it frees the same cycle the shifter consumes it,
// so a new word can be taken while the old one moves into the shifter.
module serializer_holding_reg #(
  parameter int W = 32
) (
  input  logic         high_speed_clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         shifter_free,
  output logic         pend_valid,
  output logic [W-1:0] pend_data
);
  logic         pend_valid_q, pend_valid_d;
  logic [W-1:0] pend_data_q, pend_data_d;
  logic         accept;

  assign in_ready = !reset && (!pend_valid_q || shifter_free);
  assign accept   = in_valid && in_ready;

  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    if (accept) begin
      pend_valid_d = 1'b1;
      pend_data_d  = in_data;
    end else if (shifter_free) begin
      // a pending word here is being loaded into the shifter this edge
      pend_valid_d = 1'b0;
    end
  end

  always_ff @(posedge high_speed_clock) begin
    if (reset) begin
      pend_valid_q <= 1'b0;
    end else begin
      pend_valid_q <= pend_valid_d;
    end
    pend_data_q <= pend_data_d;
  end

  assign pend_valid = pend_valid_q;
  assign pend_data  = pend_data_q;
endmodule

// File: rtl/serializer.sv
// Sends each D*S-bit word as S D-bit slices, LSB slice first, with a frame-start
// strobe on slice 0; back-to-back words stream with no idle beat between frames.
module serializer
  import serializer_pkg::*;
#(
  parameter int            D         = 8,
  parameter int            S         = 4,
  parameter logic [D-1:0]  IDLE_WORD = '0
) (
  input  logic           high_speed_clock,
  input  logic           reset,
  serializer_if.slave    bus
);
  localparam int            CW   = $clog2(S);
  localparam logic [CW-1:0] LAST = CW'(S - 1);

  ser_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [D*S-1:0]  sh_data_q, sh_data_d;
  logic [D-1:0]    out_data_q, out_data_d;
  logic            out_frame_start_q, out_frame_start_d;
  logic            out_active_q, out_active_d;

  logic            shifter_free;
  logic            pend_valid;
  logic [D*S-1:0]  pend_data;
  logic            load;

  assign shifter_free = (state_q == ST_IDLE) || (cnt_q == LAST);
  assign load         = shifter_free && pend_valid;

  serializer_holding_reg #(.W(D*S)) u_hold (
    .high_speed_clock (high_speed_clock),
    .reset            (reset),
    .in_valid         (bus.in_valid),
    .in_ready         (bus.in_ready),
    .in_data          (bus.in_data),
    .shifter_free     (shifter_free),
    .pend_valid       (pend_valid),
    .pend_data        (pend_data)
  );

  always_ff @(posedge high_speed_clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (pend_valid) state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == LAST && !pend_valid) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // The shift register moves down one slice per beat, so the next slice is always at [2D-1:D].
  always_comb begin
    cnt_d             = cnt_q;
    sh_data_d         = sh_data_q;
    out_data_d        = IDLE_WORD;
    out_frame_start_d = 1'b0;
    out_active_d      = 1'b0;
    if (load) begin
      sh_data_d         = pend_data;
      out_data_d        = pend_data[D-1:0];
      cnt_d             = '0;
      out_frame_start_d = 1'b1;
      out_active_d      = 1'b1;
    end else if (state_q == ST_SHIFT && cnt_q != LAST) begin
      cnt_d        = cnt_q + CW'(1);
      sh_data_d    = sh_data_q >> D;
      out_data_d   = sh_data_q[2*D-1:D];
      out_active_d = 1'b1;
    end
  end

  always_ff @(posedge high_speed_clock) begin
    if (reset) begin
      cnt_q             <= '0;
      out_data_q        <= IDLE_WORD;
      out_frame_start_q <= 1'b0;
      out_active_q      <= 1'b0;
    end else begin
      cnt_q             <= cnt_d;
      out_data_q        <= out_data_d;
      out_frame_start_q <= out_frame_start_d;
      out_active_q      <= out_active_d;
    end
    sh_data_q <= sh_data_d;
  end

  assign bus.out_data        = out_data_q;
  assign bus.out_frame_start = out_frame_start_q;
  assign bus.out_active      = out_active_q;
endmodule

// File: tb/tb_serializer.sv
// Drives directed and random words into the serializer and checks every output beat
// against a schedule model: each word starts at max(accept+1, previous start+S).
module tb_serializer;
  localparam int D = 8;
  localparam int S = 4;

  logic high_speed_clock = 1'b0;
  logic reset            = 1'b1;

  serializer_if #(.D(D), .S(S)) bus ();

  serializer #(.D(D), .S(S), .IDLE_WORD(8'h00)) dut (
    .high_speed_clock (high_speed_clock),
    .reset            (reset),
    .bus              (bus)
  );

  always #5 high_speed_clock = ~high_speed_clock;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  bit armed = 0;
  bit accepted;

  logic [D*S-1:0] w_q[$];
  int             s_q[$];
  int             last_start = -100;
  logic [D*S-1:0] sent_q[$];
  logic [D*S-1:0] asm_word;
  int             asm_n = -1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_outputs();
    logic [D-1:0]   ed;
    logic           ea;
    logic           ef;
    logic [D*S-1:0] w;
    logic [D*S-1:0] slice_ext;
    int             k;
    ed = 8'h00;
    ea = 1'b0;
    ef = 1'b0;
    while (s_q.size() > 0 && s_q[0] + S <= cyc) begin
      void'(s_q.pop_front());
      void'(w_q.pop_front());
    end
    if (s_q.size() > 0 && s_q[0] <= cyc) begin
      k  = cyc - s_q[0];
      w  = w_q[0];
      ed = D'(w >> (k * D));
      ea = 1'b1;
      ef = (k == 0);
    end
    chk("out_data", 64'(bus.out_data), 64'(ed));
    chk("out_active", 64'(bus.out_active), 64'(ea));
    chk("out_frame_start", 64'(bus.out_frame_start), 64'(ef));

    // reassemble words from the lane as a downstream deserializer would
    if (bus.out_frame_start) begin
      asm_word = '0;
      asm_n    = 0;
    end
    if (asm_n >= 0 && bus.out_active) begin
      slice_ext = '0;
      slice_ext[D-1:0] = bus.out_data;
      asm_word = asm_word | (slice_ext << (asm_n * D));
      asm_n++;
      if (asm_n == S) begin
        if (sent_q.size() > 0) chk("word", 64'(asm_word), 64'(sent_q.pop_front()));
        else chk("word_pending", 64'(sent_q.size()), 64'd1);
        asm_n = -1;
      end
    end
  endtask

  task automatic step(input bit v, input logic [D*S-1:0] d, input bit r);
    bit er;
    int st;
    if (armed) check_outputs();
    reset        = r;
    bus.in_valid = v;
    bus.in_data  = d;
    #1;
    er = !r && (last_start <= cyc + 1);
    chk("in_ready", 64'(bus.in_ready), 64'(er));
    accepted = v && er;
    if (r) begin
      w_q.delete();
      s_q.delete();
      sent_q.delete();
      asm_n      = -1;
      last_start = -100;
      armed      = 1;
    end else if (accepted) begin
      st = (cyc + 2 > last_start + S) ? cyc + 2 : last_start + S;
      w_q.push_back(d);
      s_q.push_back(st);
      sent_q.push_back(d);
      last_start = st;
    end
    @(posedge high_speed_clock);
    cyc++;
    @(negedge high_speed_clock);
  endtask

  task automatic offer(input logic [D*S-1:0] w);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, w, 1'b0);
      if (accepted) return;
    end
    chk("offer_timeout", 64'(accepted), 64'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom, 1'b0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
    idle(2);

    // single word
    offer(32'h44332211);
    idle(7);

    // back-to-back
    offer(32'h44332211);
    offer(32'h88776655);
    idle(9);

    // backpressure with three words
    offer(32'hA3A2A1A0);
    offer(32'hB3B2B1B0);
    offer(32'hC3C2C1C0);
    idle(14);

    // reset after slice 0x22 with a second word pending
    offer(32'h44332211);
    offer(32'h88776655);
    idle(1);
    step(1'b0, '0, 1'b1);
    idle(10);

    // random traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 99) < 70, $urandom, $urandom_range(0, 199) == 0);
    end
    idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
